// File: rtl/skip_seq_checker_if.sv
// Sample/result bundle between a mod-16 skip counter under test and its checker.
// The checker takes the slave view; the stimulus side takes the master view.
interface skip_seq_checker_if #(
    parameter int W     = 4,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic [W-1:0]     in_cnt;
    logic             clr_err;
    logic             locked;
    logic [W-1:0]     expected;
    logic             err_pulse;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic             wrap_pulse;
    logic [15:0]      wrap_count;

    modport master (
        output in_valid, in_cnt, clr_err,
        input  locked, expected, err_pulse, err_sticky, err_count, wrap_pulse, wrap_count
    );

    modport slave (
        input  in_valid, in_cnt, clr_err,
        output locked, expected, err_pulse, err_sticky, err_count, wrap_pulse, wrap_count
    );
endinterface

// File: rtl/skip_seq_checker.sv
// Monitors a skip counter (0..9,11,13,15,0): locks onto the sequence, then flags,
// counts and recovers from step errors and counts completed wraps. All outputs registered.
module skip_seq_checker #(
    parameter int W           = 4,
    parameter int SKIP_THRESH = 8,
    parameter int MAXV        = 15,
    parameter int LOCK_N      = 4,
    parameter int UNLOCK_N    = 3,
    parameter int ERR_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    skip_seq_checker_if.slave    bus
);

    localparam int RUN_W = $clog2(LOCK_N + UNLOCK_N + 1);
    localparam logic [W-1:0]     MAX_V    = W'(MAXV);
    localparam logic [W-1:0]     THRESH_V = W'(SKIP_THRESH);
    localparam logic [RUN_W-1:0] LOCK_V   = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] UNLOCK_V = RUN_W'(UNLOCK_N);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        SLIP    = 2'd3
    } state_t;

    // Successor of v; the sum is formed one bit wider so an overshoot past MAXV folds to 0.
    function automatic logic [W-1:0] step(input logic [W-1:0] v);
        logic [W:0] sum;
        if (v > THRESH_V) begin
            sum = {1'b0, v} + (W+1)'(2);
        end else begin
            sum = {1'b0, v} + (W+1)'(1);
        end
        if ((v == MAX_V) || (sum > {1'b0, MAX_V})) begin
            step = {W{1'b0}};
        end else begin
            step = sum[W-1:0];
        end
    endfunction

    state_t           state_r, state_n;
    logic [W-1:0]     last_r, last_n;
    logic [RUN_W-1:0] good_run_r, good_run_n;
    logic [RUN_W-1:0] bad_run_r, bad_run_n;
    logic [W-1:0]     expected_r, expected_n;
    logic             err_pulse_r, err_sticky_r, err_sticky_n;
    logic [ERR_W-1:0] err_count_r, err_count_n, err_base_s;
    logic             wrap_pulse_r;
    logic [15:0]      wrap_count_r, wrap_count_n;
    logic             locked_r;
    logic             good_s, err_hit_s, wrap_hit_s;

    // Next-state, run counters and event detection for one valid sample.
    always_comb begin
        state_n    = state_r;
        last_n     = last_r;
        good_run_n = good_run_r;
        bad_run_n  = bad_run_r;
        expected_n = expected_r;
        err_hit_s  = 1'b0;
        wrap_hit_s = 1'b0;
        good_s     = (bus.in_cnt == step(last_r));
        if (bus.in_valid) begin
            last_n = bus.in_cnt;
            case (state_r)
                SEARCH: begin
                    state_n    = ACQUIRE;
                    good_run_n = {RUN_W{1'b0}};
                    bad_run_n  = {RUN_W{1'b0}};
                end
                ACQUIRE: begin
                    if (!good_s) begin
                        good_run_n = {RUN_W{1'b0}};
                    end else if (good_run_r + RUN_W'(1) >= LOCK_V) begin
                        state_n    = LOCKED;
                        good_run_n = {RUN_W{1'b0}};
                    end else begin
                        good_run_n = good_run_r + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (good_s) begin
                        wrap_hit_s = (last_r == MAX_V);
                    end else begin
                        err_hit_s = 1'b1;
                        if (UNLOCK_V == RUN_W'(1)) begin
                            state_n   = SEARCH;
                            bad_run_n = {RUN_W{1'b0}};
                        end else begin
                            state_n   = SLIP;
                            bad_run_n = RUN_W'(1);
                        end
                    end
                end
                SLIP: begin
                    if (good_s) begin
                        state_n   = LOCKED;
                        bad_run_n = {RUN_W{1'b0}};
                    end else begin
                        err_hit_s = 1'b1;
                        if (bad_run_r + RUN_W'(1) >= UNLOCK_V) begin
                            state_n   = SEARCH;
                            bad_run_n = {RUN_W{1'b0}};
                        end else begin
                            bad_run_n = bad_run_r + RUN_W'(1);
                        end
                    end
                end
                default: begin
                    state_n    = SEARCH;
                    good_run_n = {RUN_W{1'b0}};
                    bad_run_n  = {RUN_W{1'b0}};
                end
            endcase
            if (state_n == SEARCH) begin
                expected_n = {W{1'b0}};
            end else begin
                expected_n = step(bus.in_cnt);
            end
        end else begin
            state_n = state_r;
        end
    end

    // Error/wrap bookkeeping: a clear applies before a same-cycle error is counted.
    always_comb begin
        if (bus.clr_err) begin
            err_base_s   = {ERR_W{1'b0}};
            err_sticky_n = 1'b0;
        end else begin
            err_base_s   = err_count_r;
            err_sticky_n = err_sticky_r;
        end
        if (err_hit_s && (err_base_s != {ERR_W{1'b1}})) begin
            err_count_n = err_base_s + ERR_W'(1);
        end else begin
            err_count_n = err_base_s;
        end
        if (err_hit_s) begin
            err_sticky_n = 1'b1;
        end else begin
            err_sticky_n = err_sticky_n;
        end
        if (wrap_hit_s && (wrap_count_r != 16'hFFFF)) begin
            wrap_count_n = wrap_count_r + 16'd1;
        end else begin
            wrap_count_n = wrap_count_r;
        end
    end

    // State and output registers; rst overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= SEARCH;
            last_r       <= {W{1'b0}};
            good_run_r   <= {RUN_W{1'b0}};
            bad_run_r    <= {RUN_W{1'b0}};
            expected_r   <= {W{1'b0}};
            err_pulse_r  <= 1'b0;
            err_sticky_r <= 1'b0;
            err_count_r  <= {ERR_W{1'b0}};
            wrap_pulse_r <= 1'b0;
            wrap_count_r <= 16'd0;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= state_n;
            last_r       <= last_n;
            good_run_r   <= good_run_n;
            bad_run_r    <= bad_run_n;
            expected_r   <= expected_n;
            err_pulse_r  <= err_hit_s;
            err_sticky_r <= err_sticky_n;
            err_count_r  <= err_count_n;
            wrap_pulse_r <= wrap_hit_s;
            wrap_count_r <= wrap_count_n;
            locked_r     <= (state_n == LOCKED);
        end
    end

    assign bus.locked     = locked_r;
    assign bus.expected   = expected_r;
    assign bus.err_pulse  = err_pulse_r;
    assign bus.err_sticky = err_sticky_r;
    assign bus.err_count  = err_count_r;
    assign bus.wrap_pulse = wrap_pulse_r;
    assign bus.wrap_count = wrap_count_r;

endmodule
